cycle_sequencer: RTL
====================

# cycle_sequencer

Parametrised instruction-cycle sequencer; next generation of the 8-cycle A1–X3 counter. Generates a configurable-length cycle index with one-hot phase decode, SYNC on the last cycle, hold/stall, single-step mode, a retired-instruction counter and a synchronised reset release. Sits between the toggle clock source and the CPU core; every core stage decodes `cycle`/`phase` from it.

## Interface
- `CYCLES`, 8, cycles per instruction (≥2); index 0 = A1, CYCLES-1 = X3 when 8.
- `CNT_W`, 16, width of retired-instruction counter.
- `CW` (localparam), max(1, clog2(CYCLES)), width of `cycle`.
- `toggleClk` in 1 — clock; all state on posedge.
- `rstN` in 1 — reset rstN, asynchronous, active-low.
- `runMode` in 1 — 1 free-run, 0 single-step.
- `stepReq` in 1 — level; each rising edge requests one instruction in step mode.
- `hold` in 1 — stall: freezes counter, FSM, instrCount.
- `rstSyncN` out 1 — synchronised reset for downstream (async assert, 2-flop release).
- `cycle` out CW — current cycle index.
- `phase` out CYCLES — one-hot of `cycle`.
- `sync` out 1 — high while `cycle == CYCLES-1`.
- `instrDone` out 1 — high when last cycle advances to 0 this edge.
- `parked` out 1 — high while waiting for a step in step mode.
- `instrCount` out CNT_W — retired instructions, wraps modulo 2^CNT_W.

## Operation
- FSM states: WAIT_RST, RUN, PARK.
- WAIT_RST: entered on rstN low; leaves to RUN on first posedge with rstSyncN=1 (no advance that edge).
- advance = (state==RUN) & ~hold. On advance: cycle = (cycle==CYCLES-1) ? 0 : cycle+1.
- At boundary (cycle==CYCLES-1 with advance): if runMode=0 and no pending step → go PARK, cycle=0; else stay RUN. runMode changes mid-instruction take effect only at a boundary.
- Entering step mode from RUN: also parks if runMode=0 at cycle 0 right after WAIT_RST.
- PARK: cycle held 0, parked=1. If pending step (or runMode=1) and ~hold → RUN, consume pending; cycle advances on the following edge.
- stepReq rising edge (registered edge detect, always active, even during hold) sets pending; consumed on PARK→RUN; a second edge while pending is dropped.
- instrDone = sync & advance (combinational); instrCount increments on that edge.
- hold during PARK keeps PARK; pending retained.

## Timing
- Reset values: rstSyncN=0, cycle=0, phase=1 (bit0), sync=0, instrDone=0, parked=0, instrCount=0, pending=0, state WAIT_RST.
- rstN deassert: edge1 s1=1, edge2 rstSyncN=1, edge3 state→RUN, edge4 cycle 0→1.
- rstN asserted mid-instruction: all outputs to reset values immediately (async), regardless of hold.
- Free-run period: CYCLES clocks per instruction; sync high exactly 1 of CYCLES.
- Step mode: stepReq edge at edge n registered at n; PARK→RUN at n+1; cycle=1 at n+2; back to PARK after CYCLES-1 more advances.
- hold high: outputs constant; sync/instrDone gated (instrDone=0).

## Structure
- Package `cycle_pkg`: state enum, cycle name constants A1..X3 for CYCLES=8, phase index helpers.
- Sub-module `reset_sync` (2-flop async-assert/sync-release); remainder in one module.

## Test plan
- Reset release, runMode=1, CYCLES=8 → rstSyncN rises edge 2, cycle 0..7 repeating from edge 4; sync high on cycle 7 only; instrCount=3 after 24 advances.
- hold for 5 clocks at cycle 3 → cycle stays 3, instrCount unchanged, resumes 4 next edge after release.
- runMode=0 from reset, two stepReq pulses 20 clocks apart → exactly two instructions, parked=1 between, instrCount=2.
- stepReq edge during hold while parked → step executes after hold drops; second edge while pending ignored.
- runMode 1→0 at cycle 4 → instruction completes to 7, parks at 0; CYCLES=5, CNT_W=2 → wraps 3→0 after 4 instructions.
- rstN low at cycle 5 with hold=1 → all outputs reset immediately, restart per release sequence.

Source files
------------

// File: rtl/cycle_sequencer_pkg.sv
// Shared types and constants for the instruction-cycle sequencer.
// Cycle names match the classic 8-cycle A1..X3 layout.
package cycle_pkg;

  typedef enum logic [1:0] {
    WAIT_RST = 2'd0,
    RUN      = 2'd1,
    PARK     = 2'd2
  } seq_state_e;

  localparam int A1 = 0;
  localparam int A2 = 1;
  localparam int A3 = 2;
  localparam int A4 = 3;
  localparam int A5 = 4;
  localparam int X1 = 5;
  localparam int X2 = 6;
  localparam int X3 = 7;

  // Width of the cycle index; never narrower than one bit.
  function automatic int cycle_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

  // Bit position in the one-hot phase vector that marks the last cycle.
  function automatic int last_phase_bit(input int cycles);
    return cycles - 1;
  endfunction

endpackage

// File: rtl/cycle_sequencer_reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the
// second clock edge after rstN goes high.
module reset_sync (
  input  logic toggleClk,
  input  logic rstN,
  output logic rstSyncN
);

  logic s1;

  always_ff @(posedge toggleClk or negedge rstN) begin
    if (!rstN) begin
      s1       <= 1'b0;
      rstSyncN <= 1'b0;
    end else begin
      s1       <= 1'b1;
      rstSyncN <= s1;
    end
  end

endmodule

// File: rtl/cycle_sequencer.sv
// Instruction-cycle sequencer: cycle index, one-hot phase, sync/instrDone,
// hold, single-step parking and a retired-instruction counter.
module cycle_sequencer
  import cycle_pkg::*;
#(
  parameter  int CYCLES = 8,
  parameter  int CNT_W  = 16,
  localparam int CW     = cycle_width(CYCLES)
) (
  input  logic              toggleClk,
  input  logic              rstN,
  input  logic              runMode,
  input  logic              stepReq,
  input  logic              hold,
  output logic              rstSyncN,
  output logic [CW-1:0]     cycle,
  output logic [CYCLES-1:0] phase,
  output logic              sync,
  output logic              instrDone,
  output logic              parked,
  output logic [CNT_W-1:0]  instrCount
);

  localparam logic [CW-1:0]     LAST    = CW'(CYCLES - 1);
  localparam logic [CYCLES-1:0] PH_ONE  = CYCLES'(1);

  seq_state_e state;
  logic       stepPrev;
  logic       pending;
  logic       stepRise;
  logic       advance;
  logic       atLast;
  logic       consume;

  reset_sync u_reset_sync (
    .toggleClk (toggleClk),
    .rstN      (rstN),
    .rstSyncN  (rstSyncN)
  );

  assign stepRise  = stepReq & ~stepPrev;
  assign advance   = (state == RUN) & ~hold;
  assign atLast    = (cycle == LAST);
  assign sync      = atLast & ~hold;
  assign instrDone = sync & advance;
  assign parked    = (state == PARK);
  assign phase     = PH_ONE << cycle;

  // A pending step is used either to leave PARK or to chain straight into
  // the next instruction at a step-mode boundary.
  always_comb begin
    consume = 1'b0;
    if (state == PARK && !hold && (pending || runMode))
      consume = pending;
    else if (advance && atLast && !runMode)
      consume = pending;
  end

  always_ff @(posedge toggleClk or negedge rstN) begin
    if (!rstN) begin
      state      <= WAIT_RST;
      cycle      <= CW'(A1);
      instrCount <= '0;
      pending    <= 1'b0;
      stepPrev   <= 1'b0;
    end else begin
      stepPrev <= stepReq;
      if (consume)
        pending <= 1'b0;
      else if (stepRise)
        pending <= 1'b1;

      unique case (state)
        WAIT_RST: begin
          if (rstSyncN)
            state <= runMode ? RUN : PARK;
        end
        RUN: begin
          if (!hold) begin
            if (atLast) begin
              cycle      <= '0;
              instrCount <= instrCount + CNT_W'(1);
              if (!runMode && !pending)
                state <= PARK;
            end else begin
              cycle <= cycle + CW'(1);
            end
          end
        end
        PARK: begin
          if (!hold && (pending || runMode))
            state <= RUN;
        end
        default: state <= WAIT_RST;
      endcase
    end
  end

endmodule
